ram_ecc_scrubber: RTL and testbench

- Background scrubber for one SRAM block in SDP-split mode with ECC enabled. It drives the block's read/write port and consumes the block's ECC-corrected read data and error flags.
- It sweeps every 40-bit word in turn, counts single-bit (SEC) and double-bit (DED) errors, and writes corrected data back on SEC. It also records the first DED address.
- It sits between the configuration/ILA control logic and the RAM port. The RAM port is configured for 40-bit input/output width, with the read path on the same clock.

---
 rtl/ram_ecc_scrubber.sv | 180 ++++++++++++++++++
 tb/tb_ram_ecc_scrubber.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ecc_scrubber.sv
// Background ECC scrubber: sweeps all words of one SRAM block, counts SEC/DED events,
// records the first DED address. Define RAM_ECC_SCRUBBER_WRITEBACK_EN to write SEC words back.
module ram_ecc_scrubber #(
  parameter int unsigned WORDS      = 512,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ram_cs_o,
  output logic             ram_re_o,
  output logic             ram_we_o,
  output logic [15:0]      ram_addr_o,
  output logic [39:0]      ram_wrdata_o,
  output logic [39:0]      ram_bitmask_o,
  input  logic [39:0]      ram_rddata_i,
  input  logic             ecc_single_i,
  input  logic             ecc_double_i,
  output logic [CNT_W-1:0] sec_cnt_o,
  output logic [CNT_W-1:0] ded_cnt_o,
  output logic             ded_valid_o,
  output logic [8:0]       ded_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [8:0] LAST_WORD = 9'(WORDS - 1);

  state_t           state_q, state_d;
  logic [8:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] sec_q, sec_d, ded_q, ded_d;
  logic             dvalid_q, dvalid_d;
  logic [8:0]       daddr_q, daddr_d;
  logic             advance;
  logic             busy_q, done_q, cs_q, re_q;
  logic [15:0]      addr_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sec_d    = sec_q;
    ded_d    = ded_q;
    dvalid_d = dvalid_q;
    daddr_d  = daddr_q;
    advance  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sec_d    = '0;
          ded_d    = '0;
          dvalid_d = 1'b0;
          daddr_d  = '0;
          ptr_d    = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (abort_i)                state_d = S_IDLE;
        else if (RD_LATENCY == 2)   state_d = S_WAIT;
        else                        state_d = S_CHECK;
      end
      S_WAIT: state_d = abort_i ? S_IDLE : S_CHECK;
      S_CHECK: begin
        if (ecc_double_i) begin
          if (ded_q != '1) ded_d = ded_q + 1'b1;
          if (!dvalid_q) begin
            dvalid_d = 1'b1;
            daddr_d  = ptr_q;
          end
          advance = 1'b1;
        end else if (ecc_single_i) begin
          if (sec_q != '1) sec_d = sec_q + 1'b1;
`ifdef RAM_ECC_SCRUBBER_WRITEBACK_EN
          state_d = S_WRITE;
`else
          advance = 1'b1;
`endif
        end else begin
          advance = 1'b1;
        end
        // the sample above is still counted when aborting in this cycle
        if (abort_i) begin
          advance = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (abort_i) state_d = S_IDLE;
        else         advance = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (ptr_q == LAST_WORD) begin
        state_d = S_DONE;
      end else begin
        ptr_d   = ptr_q + 9'd1;
        state_d = S_READ;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sec_q    <= '0;
      ded_q    <= '0;
      dvalid_q <= 1'b0;
      daddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sec_q    <= sec_d;
      ded_q    <= ded_d;
      dvalid_q <= dvalid_d;
      daddr_q  <= daddr_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      cs_q     <= (state_d == S_READ) || (state_d == S_WRITE);
      re_q     <= (state_d == S_READ);
      addr_q   <= ((state_d == S_READ) || (state_d == S_WRITE)) ? {1'b0, ptr_d, 6'b0} : '0;
    end
  end

`ifdef RAM_ECC_SCRUBBER_WRITEBACK_EN
  logic        we_q;
  logic [39:0] wrdata_q, mask_q;

  // WRITE is only entered from CHECK, so the corrected word is still on the read bus.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q     <= 1'b0;
      wrdata_q <= '0;
      mask_q   <= '0;
    end else begin
      we_q     <= (state_d == S_WRITE);
      wrdata_q <= (state_d == S_WRITE) ? ram_rddata_i : '0;
      mask_q   <= (state_d == S_WRITE) ? '1 : '0;
    end
  end

  assign ram_we_o      = we_q;
  assign ram_wrdata_o  = wrdata_q;
  assign ram_bitmask_o = mask_q;
`else
  assign ram_we_o      = 1'b0;
  assign ram_wrdata_o  = '0;
  assign ram_bitmask_o = '0;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ram_cs_o    = cs_q;
  assign ram_re_o    = re_q;
  assign ram_addr_o  = addr_q;
  assign sec_cnt_o   = sec_q;
  assign ded_cnt_o   = ded_q;
  assign ded_valid_o = dvalid_q;
  assign ded_addr_o  = daddr_q;

endmodule

// File: tb/tb_ram_ecc_scrubber.sv
// Scoreboard bench for ram_ecc_scrubber: expected RAM accesses and done results are queued
// by the stimulus and consumed by per-instance monitors.
module tb_ram_ecc_scrubber;

`ifdef RAM_ECC_SCRUBBER_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance 1: defaults
  logic s1, a1, busy1, done1, cs1, re1, we1, sg1, db1, dv1;
  logic [15:0] addr1;
  logic [39:0] wd1, bm1, rd1;
  logic [7:0]  sec1, ded1;
  logic [8:0]  da1;
  // instance 2: 16 words, 2-cycle read latency, 4-bit counters
  logic s2, a2, busy2, done2, cs2, re2, we2, sg2, db2, dv2;
  logic [15:0] addr2;
  logic [39:0] wd2, bm2, rd2;
  logic [3:0]  sec2, ded2;
  logic [8:0]  da2;

  ram_ecc_scrubber #(.WORDS(512), .RD_LATENCY(1), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s1), .abort_i(a1), .busy_o(busy1), .done_o(done1),
    .ram_cs_o(cs1), .ram_re_o(re1), .ram_we_o(we1), .ram_addr_o(addr1), .ram_wrdata_o(wd1),
    .ram_bitmask_o(bm1), .ram_rddata_i(rd1), .ecc_single_i(sg1), .ecc_double_i(db1),
    .sec_cnt_o(sec1), .ded_cnt_o(ded1), .ded_valid_o(dv1), .ded_addr_o(da1));

  ram_ecc_scrubber #(.WORDS(16), .RD_LATENCY(2), .CNT_W(4)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s2), .abort_i(a2), .busy_o(busy2), .done_o(done2),
    .ram_cs_o(cs2), .ram_re_o(re2), .ram_we_o(we2), .ram_addr_o(addr2), .ram_wrdata_o(wd2),
    .ram_bitmask_o(bm2), .ram_rddata_i(rd2), .ecc_single_i(sg2), .ecc_double_i(db2),
    .sec_cnt_o(sec2), .ded_cnt_o(ded2), .ded_valid_o(dv2), .ded_addr_o(da2));

  function automatic logic [39:0] data_of(input logic [8:0] w);
    return {7'h35, w, 8'hC3, 7'h00, w};
  endfunction

  // memory models: flags are only asserted in the cycle the response is due
  bit e_sec1[512];
  bit e_ded1[512];
  bit e_sec2[16];
  bit e_ded2[16];
  logic [39:0] m_rd;
  logic        m_sg, m_db;

  always @(posedge clk) begin
    if (cs1 && re1) begin
      rd1 <= data_of(addr1[14:6]);
      sg1 <= e_sec1[addr1[14:6]];
      db1 <= e_ded1[addr1[14:6]];
    end else begin
      sg1 <= 1'b0;
      db1 <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (cs2 && re2) begin
      m_rd <= data_of(addr2[14:6]);
      m_sg <= e_sec2[addr2[9:6]];
      m_db <= e_ded2[addr2[9:6]];
    end else begin
      m_sg <= 1'b0;
      m_db <= 1'b0;
    end
    rd2 <= m_rd;
    sg2 <= m_sg;
    db2 <= m_db;
  end

  typedef struct packed {
    logic        we;
    logic [8:0]  word;
    logic [39:0] data;
  } acc_t;

  typedef struct packed {
    longint unsigned cyc;
    logic [7:0]      sec;
    logic [7:0]      ded;
    logic            dv;
    logic [8:0]      da;
  } done_t;

  acc_t  q_acc1[$];
  acc_t  q_acc2[$];
  done_t q_done1[$];
  done_t q_done2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    acc_t  e;
    done_t d;
    if (rst_n && cs1) begin
      if (q_acc1.size() == 0) begin
        checks++; errors++;
        $display("FAIL acc1_unexpected actual=addr %0h we %0b required=no access", addr1, we1);
      end else begin
        e = q_acc1.pop_front();
        chk("acc1_we", 64'(we1), 64'(e.we));
        chk("acc1_re", 64'(re1), 64'(!e.we));
        chk("acc1_addr", 64'(addr1), 64'({1'b0, e.word, 6'b0}));
        chk("acc1_wdata", 64'(wd1), e.we ? 64'(e.data) : 64'd0);
        chk("acc1_mask", 64'(bm1), e.we ? 64'h00FF_FFFF_FFFF : 64'd0);
      end
    end
    if (rst_n && done1) begin
      if (q_done1.size() == 0) begin
        checks++; errors++;
        $display("FAIL done1_unexpected actual=pulse at %0d required=no pulse", cyc);
      end else begin
        d = q_done1.pop_front();
        chk("done1_cycle", 64'(cyc), 64'(d.cyc));
        chk("done1_sec", 64'(sec1), 64'(d.sec));
        chk("done1_ded", 64'(ded1), 64'(d.ded));
        chk("done1_dvalid", 64'(dv1), 64'(d.dv));
        chk("done1_daddr", 64'(da1), 64'(d.da));
      end
    end
  end

  always @(negedge clk) begin : mon2
    acc_t  e;
    done_t d;
    if (rst_n && cs2) begin
      if (q_acc2.size() == 0) begin
        checks++; errors++;
        $display("FAIL acc2_unexpected actual=addr %0h we %0b required=no access", addr2, we2);
      end else begin
        e = q_acc2.pop_front();
        chk("acc2_we", 64'(we2), 64'(e.we));
        chk("acc2_re", 64'(re2), 64'(!e.we));
        chk("acc2_addr", 64'(addr2), 64'({1'b0, e.word, 6'b0}));
      end
    end
    if (rst_n && done2) begin
      if (q_done2.size() == 0) begin
        checks++; errors++;
        $display("FAIL done2_unexpected actual=pulse at %0d required=no pulse", cyc);
      end else begin
        d = q_done2.pop_front();
        chk("done2_cycle", 64'(cyc), 64'(d.cyc));
        chk("done2_sec", 64'(sec2), 64'(d.sec));
        chk("done2_ded", 64'(ded2), 64'(d.ded));
        chk("done2_dvalid", 64'(dv2), 64'(d.dv));
        chk("done2_daddr", 64'(da2), 64'(d.da));
      end
    end
  end

  task automatic push_reads1(input int first, input int last);
    acc_t e;
    for (int w = first; w <= last; w++) begin
      e.we = 1'b0; e.word = 9'(w); e.data = '0;
      q_acc1.push_back(e);
      if (WB && e_sec1[w] && !e_ded1[w]) begin
        e.we = 1'b1; e.data = data_of(9'(w));
        q_acc1.push_back(e);
      end
    end
  endtask

  task automatic push_reads2(input int first, input int last);
    acc_t e;
    for (int w = first; w <= last; w++) begin
      e.we = 1'b0; e.word = 9'(w); e.data = '0;
      q_acc2.push_back(e);
    end
  endtask

  task automatic push_done(input bit inst, input longint unsigned c, input int sec, input int ded,
                           input bit dv, input int da);
    done_t d;
    d.cyc = c; d.sec = 8'(sec); d.ded = 8'(ded); d.dv = dv; d.da = 9'(da);
    if (inst) q_done2.push_back(d);
    else      q_done1.push_back(d);
  endtask

  task automatic start1(output longint unsigned k);
    @(negedge clk); s1 = 1'b1; k = cyc + 1;
    @(negedge clk); s1 = 1'b0;
    chk("busy1_rise", 64'(busy1), 64'd1);
  endtask

  task automatic start2(output longint unsigned k);
    @(negedge clk); s2 = 1'b1; k = cyc + 1;
    @(negedge clk); s2 = 1'b0;
    chk("busy2_rise", 64'(busy2), 64'd1);
  endtask

  task automatic drain1(input string name, input int budget);
    int n = 0;
    while ((busy1 || q_acc1.size() != 0 || q_done1.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(n >= budget), 64'd0);
  endtask

  task automatic drain2(input string name, input int budget);
    int n = 0;
    while ((busy2 || q_acc2.size() != 0 || q_done2.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(n >= budget), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned k;
    int n;
    s1 = 1'b0; a1 = 1'b0; s2 = 1'b0; a2 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy1, done1, cs1, re1, we1, dv1}), 64'd0);
    chk("reset_bus", 64'(addr1) | 64'(wd1) | 64'(bm1), 64'd0);
    chk("reset_cnt", 64'({sec1, ded1, da1}), 64'd0);
    rst_n = 1'b1;

    // clean sweep, with a start pulse mid-sweep that must be ignored
    push_reads1(0, 511);
    start1(k);
    push_done(1'b0, k + 1024, 0, 0, 1'b0, 0);
    repeat (100) @(negedge clk);
    s1 = 1'b1; @(negedge clk); s1 = 1'b0;
    drain1("clean_drain", 2000);

    // SEC at words 3 and 200
    e_sec1[3] = 1'b1; e_sec1[200] = 1'b1;
    push_reads1(0, 511);
    start1(k);
    push_done(1'b0, k + (WB ? 1026 : 1024), 2, 0, 1'b0, 0);
    drain1("sec_drain", 2000);
    e_sec1[3] = 1'b0; e_sec1[200] = 1'b0;

    // DED at 7 and 9, both flags at 12
    e_ded1[7] = 1'b1; e_ded1[9] = 1'b1; e_ded1[12] = 1'b1; e_sec1[12] = 1'b1;
    push_reads1(0, 511);
    start1(k);
    push_done(1'b0, k + 1024, 0, 3, 1'b1, 7);
    drain1("ded_drain", 2000);
    repeat (5) @(negedge clk);
    chk("ded_hold_cnt", 64'(ded1), 64'd3);
    chk("ded_hold_addr", 64'({dv1, da1}), 64'({1'b1, 9'd7}));
    e_ded1[7] = 1'b0; e_ded1[9] = 1'b0; e_ded1[12] = 1'b0; e_sec1[12] = 1'b0;

    // abort on word 5 (during its write-back when compiled in, else during its check)
    e_sec1[5] = 1'b1;
    push_reads1(0, 5);
    start1(k);
    n = 0;
    while (!(cs1 && (WB ? we1 : (re1 && addr1[14:6] == 9'd5))) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("abort_reach", 64'(n >= 100), 64'd0);
    if (!WB) @(negedge clk);
    a1 = 1'b1; @(negedge clk); a1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_idle", 64'(busy1), 64'd0);
    chk("abort_sec_hold", 64'(sec1), 64'd1);
    chk("abort_acc_left", 64'(q_acc1.size()), 64'd0);
    e_sec1[5] = 1'b0;

    // reset during word 100, then a fresh sweep
    e_sec1[50] = 1'b1;
    push_reads1(0, 100);
    start1(k);
    n = 0;
    while (q_acc1.size() != 0 && n < 1000) begin
      @(posedge clk); n++;
    end
    chk("rst_reach", 64'(n >= 1000), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({busy1, done1, cs1, re1, we1, dv1}), 64'd0);
    chk("rst_mid_bus", 64'(addr1) | 64'(wd1) | 64'(bm1), 64'd0);
    chk("rst_mid_cnt", 64'({sec1, ded1, da1}), 64'd0);
    e_sec1[50] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_reads1(0, 511);
    start1(k);
    push_done(1'b0, k + 1024, 0, 0, 1'b0, 0);
    drain1("rst_sweep_drain", 2000);

    // latency 2: start held high across two sweeps, DED at word 4
    e_ded2[4] = 1'b1;
    push_reads2(0, 15);
    push_reads2(0, 15);
    @(negedge clk); s2 = 1'b1; k = cyc + 1;
    push_done(1'b1, k + 48, 0, 1, 1'b1, 4);
    push_done(1'b1, k + 50 + 48, 0, 1, 1'b1, 4);
    n = 0;
    while (q_done2.size() == 2 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("held_first_done", 64'(n >= 200), 64'd0);
    repeat (5) @(negedge clk);
    s2 = 1'b0;
    drain2("held_drain", 300);
    e_ded2[4] = 1'b0;

    // DED on every word: 4-bit counter must saturate at 15
    for (int w = 0; w < 16; w++) e_ded2[w] = 1'b1;
    push_reads2(0, 15);
    start2(k);
    push_done(1'b1, k + 48, 0, 15, 1'b1, 0);
    drain2("sat_drain", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
